// File: rtl/param_pq.sv
// Binary-heap priority queue: word load, bottom-up build, extract-top,
// increase-key, insert and sequential write-out of the heap array.
module param_pq #(
    parameter int DW       = 8,
    parameter int DEPTH    = 16,
    parameter int MIN_MODE = 0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          data_valid,
    input  logic [DW-1:0] data,
    input  logic          cmd_valid,
    input  logic [2:0]    cmd,
    input  logic [AW-1:0] index,
    input  logic [DW-1:0] value,
    output logic          busy,
    output logic          full,
    output logic          err,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          RAM_valid,
    output logic [AW-1:0] RAM_A,
    output logic [DW-1:0] RAM_D,
    output logic          done
);

    typedef enum logic [2:0] {IDLE, BUILD, HEAPIFY, SIFTUP, WRITE, DONE} state_t;

    localparam logic [2:0] CMD_BUILD    = 3'd0;
    localparam logic [2:0] CMD_EXTRACT  = 3'd1;
    localparam logic [2:0] CMD_INCREASE = 3'd2;
    localparam logic [2:0] CMD_INSERT   = 3'd3;
    localparam logic [2:0] CMD_WRITE    = 3'd4;

    logic [DW-1:0] heap_reg [DEPTH];
    logic [AW:0]   size_reg;
    logic [AW-1:0] cur_reg;
    logic [AW-1:0] root_reg;
    logic [AW-1:0] wr_idx_reg;
    logic          build_reg;
    logic          err_reg;
    logic          out_valid_reg;
    logic [DW-1:0] out_data_reg;
    state_t        state_reg, state_next;

    logic          err_next, load_en, cmd_go, full_w;
    logic [AW:0]   left_w;
    logic [AW+1:0] right_w;
    logic          left_in, right_in;
    logic [AW-1:0] best_idx, parent_idx, root_init, last_idx;
    logic [DW-1:0] best_key, cur_key;
    logic          down_swap, up_swap, incr_ok, wr_last;

    function automatic logic better(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (MIN_MODE != 0) return a < b;
        return a > b;
    endfunction

    assign full_w     = (size_reg == (AW+1)'(DEPTH));
    assign cur_key    = heap_reg[cur_reg];
    assign left_w     = {cur_reg, 1'b1};
    assign right_w    = {1'b0, left_w} + (AW+2)'(1);
    assign left_in    = (left_w < size_reg);
    assign right_in   = (right_w < {1'b0, size_reg});
    assign parent_idx = (cur_reg - AW'(1)) >> 1;
    assign up_swap    = (cur_reg != '0) && better(cur_key, heap_reg[parent_idx]);
    assign incr_ok    = ({1'b0, index} < size_reg) && better(value, heap_reg[index]);
    assign root_init  = AW'((size_reg >> 1) - (AW+1)'(1));
    assign last_idx   = AW'(size_reg - (AW+1)'(1));
    assign wr_last    = ({1'b0, wr_idx_reg} == (size_reg - (AW+1)'(1)));

    // Right child wins only when strictly better than the current best,
    // so equal children resolve to the left one.
    always_comb begin
        best_idx = cur_reg;
        best_key = cur_key;
        if (left_in && better(heap_reg[left_w[AW-1:0]], best_key)) begin
            best_idx = left_w[AW-1:0];
            best_key = heap_reg[left_w[AW-1:0]];
        end
        if (right_in && better(heap_reg[right_w[AW-1:0]], best_key)) begin
            best_idx = right_w[AW-1:0];
            best_key = heap_reg[right_w[AW-1:0]];
        end
    end

    assign down_swap = (best_idx != cur_reg);

    always_comb begin
        state_next = state_reg;
        err_next   = 1'b0;
        load_en    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (data_valid) begin
                    if (full_w) err_next = 1'b1;
                    else        load_en  = 1'b1;
                    if (cmd_valid) err_next = 1'b1;
                end else if (cmd_valid) begin
                    case (cmd)
                        CMD_BUILD:    state_next = BUILD;
                        CMD_EXTRACT:  if (size_reg == '0) err_next = 1'b1;
                                      else state_next = HEAPIFY;
                        CMD_INCREASE: if (!incr_ok) err_next = 1'b1;
                                      else state_next = SIFTUP;
                        CMD_INSERT:   if (full_w) err_next = 1'b1;
                                      else state_next = SIFTUP;
                        CMD_WRITE:    state_next = (size_reg == '0) ? DONE : WRITE;
                        default:      err_next = 1'b1;
                    endcase
                end
            end
            BUILD:   state_next = (size_reg < (AW+1)'(2)) ? IDLE : HEAPIFY;
            HEAPIFY: if (!down_swap) state_next = (build_reg && root_reg != '0) ? BUILD : IDLE;
            SIFTUP:  if (!up_swap) state_next = IDLE;
            WRITE:   if (wr_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign cmd_go = (state_reg == IDLE) && (state_next != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            size_reg      <= '0;
            cur_reg       <= '0;
            root_reg      <= '0;
            wr_idx_reg    <= '0;
            build_reg     <= 1'b0;
            err_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            err_reg       <= err_next;
            out_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (load_en) begin
                        heap_reg[size_reg[AW-1:0]] <= data;
                        size_reg <= size_reg + (AW+1)'(1);
                    end
                    if (cmd_go) begin
                        build_reg <= 1'b0;
                        case (cmd)
                            CMD_BUILD: root_reg <= root_init;
                            CMD_EXTRACT: begin
                                out_valid_reg <= 1'b1;
                                out_data_reg  <= heap_reg[0];
                                heap_reg[0]   <= heap_reg[last_idx];
                                size_reg      <= size_reg - (AW+1)'(1);
                                cur_reg       <= '0;
                            end
                            CMD_INCREASE: begin
                                heap_reg[index] <= value;
                                cur_reg         <= index;
                            end
                            CMD_INSERT: begin
                                heap_reg[size_reg[AW-1:0]] <= value;
                                size_reg <= size_reg + (AW+1)'(1);
                                cur_reg  <= size_reg[AW-1:0];
                            end
                            default: wr_idx_reg <= '0;
                        endcase
                    end
                end
                BUILD: begin
                    cur_reg   <= root_reg;
                    build_reg <= (size_reg >= (AW+1)'(2));
                end
                HEAPIFY: begin
                    if (down_swap) begin
                        heap_reg[cur_reg]  <= best_key;
                        heap_reg[best_idx] <= cur_key;
                        cur_reg            <= best_idx;
                    end else if (build_reg && root_reg != '0) begin
                        root_reg <= root_reg - AW'(1);
                    end else begin
                        build_reg <= 1'b0;
                    end
                end
                SIFTUP: begin
                    if (up_swap) begin
                        heap_reg[cur_reg]    <= heap_reg[parent_idx];
                        heap_reg[parent_idx] <= cur_key;
                        cur_reg              <= parent_idx;
                    end
                end
                WRITE:   wr_idx_reg <= wr_idx_reg + AW'(1);
                default: ;
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign full      = full_w;
    assign err       = err_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign RAM_valid = (state_reg == WRITE);
    assign RAM_A     = (state_reg == WRITE) ? wr_idx_reg : '0;
    assign RAM_D     = (state_reg == WRITE) ? heap_reg[wr_idx_reg] : '0;
    assign done      = (state_reg == DONE);

endmodule
